// File: rtl/can_pkg.sv
// Shared CAN constants and types for the arbitration field deserializer.
package can_pkg;

    localparam int unsigned BASE_ID_W = 11;
    localparam int unsigned EXT_ID_W  = 18;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StBase,
        StSrrRtr,
        StIdeS,
        StExt,
        StRtrExt,
        StFinal
    } arb_state_t;

endpackage

// File: rtl/arbitration_field_deserializer.sv
// Deserializes SOF..end of arbitration field into IDF/IDF_ex/IDE/RTR.
// Optional SRR form check is enabled by defining ARB_FORM_CHECK_EN.
module arbitration_field_deserializer
    import can_pkg::*;
(
    input  logic                 SP,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_abort,
    output logic [BASE_ID_W-1:0] IDF,
    output logic [EXT_ID_W-1:0]  IDF_ex,
    output logic                 IDE,
    output logic                 RTR,
    output logic                 F_IDF,
    output logic                 form_err
);

    arb_state_t           state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BASE_ID_W-1:0] idf_q, idf_d;
    logic [EXT_ID_W-1:0]  idf_ex_q, idf_ex_d;
    logic                 ide_q, ide_d;
    logic                 rtr_q, rtr_d;
    logic                 f_idf_q, f_idf_d;
`ifdef ARB_FORM_CHECK_EN
    logic                 form_err_q, form_err_d;
`endif

    always_ff @(posedge SP) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            idf_q     <= '0;
            idf_ex_q  <= '0;
            ide_q     <= 1'b0;
            rtr_q     <= 1'b0;
            f_idf_q   <= 1'b1;
`ifdef ARB_FORM_CHECK_EN
            form_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idf_q     <= idf_d;
            idf_ex_q  <= idf_ex_d;
            ide_q     <= ide_d;
            rtr_q     <= rtr_d;
            f_idf_q   <= f_idf_d;
`ifdef ARB_FORM_CHECK_EN
            form_err_q <= form_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idf_d     = idf_q;
        idf_ex_d  = idf_ex_q;
        ide_d     = ide_q;
        rtr_d     = rtr_q;
        f_idf_d   = f_idf_q;
`ifdef ARB_FORM_CHECK_EN
        form_err_d = 1'b0;
`endif
        if (frame_abort) begin
            // Abort wins over a simultaneous frame_start; data is left as captured.
            state_d = StIdle;
            f_idf_d = 1'b1;
        end else if (frame_start && bit_valid) begin
            state_d   = StBase;
            bit_cnt_d = '0;
            idf_d     = '0;
            idf_ex_d  = '0;
            ide_d     = 1'b0;
            rtr_d     = 1'b0;
            f_idf_d   = 1'b0;
        end else if (state_q == StFinal) begin
            state_d = StIdle;
            f_idf_d = 1'b1;
        end else if (bit_valid) begin
            unique case (state_q)
                StIdle: ;
                StFinal: ;
                StBase: begin
                    idf_d = {idf_q[BASE_ID_W-2:0], bit_in};
                    if (bit_cnt_q == CNT_W'(BASE_ID_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StSrrRtr;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StSrrRtr: begin
                    rtr_d   = bit_in;
                    state_d = StIdeS;
                end
                StIdeS: begin
                    ide_d = bit_in;
                    if (!bit_in) begin
                        state_d = StFinal;
                    end else begin
`ifdef ARB_FORM_CHECK_EN
                        // A dominant SRR in an extended frame is a form error.
                        if (!rtr_q) begin
                            form_err_d = 1'b1;
                            f_idf_d    = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            rtr_d     = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StExt;
                        end
`else
                        rtr_d     = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StExt;
`endif
                    end
                end
                StExt: begin
                    idf_ex_d = {idf_ex_q[EXT_ID_W-2:0], bit_in};
                    if (bit_cnt_q == CNT_W'(EXT_ID_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StRtrExt;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StRtrExt: begin
                    rtr_d   = bit_in;
                    state_d = StFinal;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        IDF    = idf_q;
        IDF_ex = idf_ex_q;
        IDE    = ide_q;
        RTR    = rtr_q;
        F_IDF  = f_idf_q;
`ifdef ARB_FORM_CHECK_EN
        form_err = form_err_q;
`else
        form_err = 1'b0;
`endif
    end

endmodule
